// File: rtl/multi_mode_shifter.sv
// Multi-cycle shifter: one bit position per enabled cycle, four modes, one-cycle done pulse.
// Optional SHIFTER_STICKY_EN adds a sticky output (OR of all bits shifted out, rotate excluded).
module multi_mode_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
`ifdef SHIFTER_STICKY_EN
  ,
  output logic             sticky
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [AMT_W-1:0] WIDTH_C = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] ONE_C   = AMT_W'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dout_reg, dout_next;
  logic [AMT_W-1:0] count_reg, count_next;
  logic [1:0]       mode_reg, mode_next;
  logic [AMT_W-1:0] eff;
  logic [WIDTH-1:0] step_vec;

`ifdef SHIFTER_STICKY_EN
  logic sticky_reg, sticky_next;
  logic shifted_out;
`endif

  // Right shifts saturate at WIDTH steps; rotation only needs the residue.
  always_comb begin
    eff = amount;
    if (mode == 2'b11) begin
      eff = amount % WIDTH_C;
    end else if (amount > WIDTH_C) begin
      eff = WIDTH_C;
    end
  end

  // One-position step, built bit by bit from the captured mode.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
      if (gi == WIDTH - 1) begin : g_msb
        assign step_vec[gi] = (mode_reg == 2'b10) ? dout_reg[gi-1] :
                              (mode_reg == 2'b00) ? dout_reg[gi]   :
                              (mode_reg == 2'b11) ? dout_reg[0]    : 1'b0;
      end else if (gi == 0) begin : g_lsb
        assign step_vec[gi] = (mode_reg == 2'b10) ? 1'b0 : dout_reg[1];
      end else begin : g_mid
        assign step_vec[gi] = (mode_reg == 2'b10) ? dout_reg[gi-1] : dout_reg[gi+1];
      end
    end
  endgenerate

`ifdef SHIFTER_STICKY_EN
  assign shifted_out = (mode_reg == 2'b10) ? dout_reg[WIDTH-1] :
                       (mode_reg == 2'b11) ? 1'b0 : dout_reg[0];
`endif

  always_comb begin
    state_next = state_reg;
    dout_next  = dout_reg;
    count_next = count_reg;
    mode_next  = mode_reg;
`ifdef SHIFTER_STICKY_EN
    sticky_next = sticky_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          dout_next = din;
          mode_next = mode;
`ifdef SHIFTER_STICKY_EN
          sticky_next = 1'b0;
`endif
          if (eff == '0) begin
            state_next = DONE;
          end else begin
            count_next = eff;
            state_next = SHIFT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (enable) begin
          dout_next  = step_vec;
          count_next = count_reg - ONE_C;
`ifdef SHIFTER_STICKY_EN
          sticky_next = sticky_reg | shifted_out;
`endif
          if (count_reg == ONE_C) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      dout_reg  <= '0;
      count_reg <= '0;
      mode_reg  <= 2'b00;
`ifdef SHIFTER_STICKY_EN
      sticky_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      dout_reg  <= dout_next;
      count_reg <= count_next;
      mode_reg  <= mode_next;
`ifdef SHIFTER_STICKY_EN
      sticky_reg <= sticky_next;
`endif
    end
  end

  assign dout = dout_reg;
  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
`ifdef SHIFTER_STICKY_EN
  assign sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_multi_mode_shifter.sv
// Bench for multi_mode_shifter (WIDTH=16): vector table, hand-written corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_multi_mode_shifter;

  logic        clk = 1'b0;
  logic        reset, start, enable;
  logic [15:0] din;
  logic [4:0]  amount;
  logic [1:0]  mode;
  logic [15:0] dout;
  logic        busy, done;
`ifdef SHIFTER_STICKY_EN
  logic        sticky;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_mode_shifter #(.WIDTH(16), .AMT_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .enable (enable),
    .din    (din),
    .amount (amount),
    .mode   (mode),
    .dout   (dout),
    .busy   (busy),
    .done   (done)
`ifdef SHIFTER_STICKY_EN
    ,
    .sticky (sticky)
`endif
  );

  typedef struct {
    logic [15:0] d;
    logic [4:0]  a;
    logic [1:0]  m;
    int          stall_after;
    int          stall_len;
    bit          poke;
    logic [15:0] exp_dout;
    int          steps;
    bit          exp_sticky;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the whole operation as one arithmetic shift of the operand.
  function automatic void model(input logic [15:0] d, input logic [4:0] a, input logic [1:0] m,
                                output logic [15:0] r, output bit s, output int eff);
    logic [31:0]        wide;
    logic signed [31:0] sx;
    eff = (m == 2'b11) ? (int'(a) % 16) : ((int'(a) > 16) ? 16 : int'(a));
    sx  = $signed({{16{d[15]}}, d});
    case (m)
      2'b00:   wide = 32'(sx >>> eff);
      2'b01:   wide = {16'h0, d} >> eff;
      2'b10:   wide = {16'h0, d} << eff;
      default: wide = {d, d} >> eff;
    endcase
    r = wide[15:0];
    case (m)
      2'b00, 2'b01: s = (({16'h0, d}) & ((32'd1 << eff) - 32'd1)) != 32'd0;
      2'b10:        s = ((({16'h0, d}) << eff) >> 16) != 32'd0;
      default:      s = 1'b0;
    endcase
  endfunction

  task automatic do_op(input string name, input logic [15:0] d, input logic [4:0] a,
                       input logic [1:0] m, input int stall_after, input int stall_len,
                       input bit rand_stall, input bit poke, input logic [15:0] exp_dout,
                       input int exp_steps, input bit exp_sticky);
    int n = 0;
    int steps = 0;
    int stalls = 0;
    bit busy_ok = 1'b1;
    din = d; amount = a; mode = m; start = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (rand_stall) enable = ($urandom_range(0, 2) != 0);
      else            enable = !(steps == stall_after && stalls < stall_len);
      if (enable) steps++; else stalls++;
      if (poke) begin
        start = 1'b1; din = 16'hAAAA; amount = 5'($urandom); mode = 2'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({name, " done"}, 32'(done), 32'd1);
    if (done !== 1'b1) begin
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      return;
    end
    chk({name, " latency"}, n, exp_steps + stalls);
    chk({name, " busy_during"}, 32'(busy_ok), 32'd1);
    chk({name, " busy_at_done"}, 32'(busy), 32'd0);
    chk({name, " dout"}, 32'(dout), 32'(exp_dout));
`ifdef SHIFTER_STICKY_EN
    chk({name, " sticky"}, 32'(sticky), 32'(exp_sticky));
`endif
    enable = 1'b1;
    @(posedge clk); #1;
    chk({name, " done_pulse"}, 32'(done), 32'd0);
    chk({name, " idle_busy"}, 32'(busy), 32'd0);
    chk({name, " dout_hold"}, 32'(dout), 32'(exp_dout));
    $display("op %s din=%h amt=%0d mode=%0d dout=%h edges=%0d stalls=%0d sticky_exp=%0d",
             name, d, a, m, dout, n, stalls, exp_sticky);
  endtask

  initial begin
    logic [15:0] r;
    bit          s;
    int          eff;
    int          n;

    tbl[0]  = '{16'hF00F, 5'd4,  2'd0, -1, 0, 1'b0, 16'hFF00, 4,  1'b1};
    tbl[1]  = '{16'hF00F, 5'd4,  2'd1, -1, 0, 1'b0, 16'h0F00, 4,  1'b1};
    tbl[2]  = '{16'hF00F, 5'd4,  2'd2, -1, 0, 1'b0, 16'h00F0, 4,  1'b1};
    tbl[3]  = '{16'h1234, 5'd4,  2'd3, -1, 0, 1'b0, 16'h4123, 4,  1'b0};
    tbl[4]  = '{16'h1234, 5'd20, 2'd3, -1, 0, 1'b0, 16'h4123, 4,  1'b0};
    tbl[5]  = '{16'h1234, 5'd16, 2'd3, -1, 0, 1'b0, 16'h1234, 0,  1'b0};
    tbl[6]  = '{16'h8001, 5'd31, 2'd0, -1, 0, 1'b0, 16'hFFFF, 16, 1'b1};
    tbl[7]  = '{16'h8001, 5'd31, 2'd1, -1, 0, 1'b0, 16'h0000, 16, 1'b1};
    tbl[8]  = '{16'h00F0, 5'd3,  2'd1,  1, 2, 1'b1, 16'h001E, 3,  1'b0};
    tbl[9]  = '{16'h0003, 5'd1,  2'd1, -1, 0, 1'b0, 16'h0001, 1,  1'b1};
    tbl[10] = '{16'h0010, 5'd4,  2'd1, -1, 0, 1'b0, 16'h0001, 4,  1'b0};

    // Reset with start held high: nothing may be accepted.
    reset = 1'b1; start = 1'b1; enable = 1'b1; din = 16'hAAAA; amount = 5'd3; mode = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("post_reset busy", 32'(busy), 32'd0);
    chk("post_reset done", 32'(done), 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].d, tbl[i].a, tbl[i].m, tbl[i].stall_after,
            tbl[i].stall_len, 1'b0, tbl[i].poke, tbl[i].exp_dout, tbl[i].steps, tbl[i].exp_sticky);
    end

    // Reset while shifting with two steps left.
    din = 16'h00F0; amount = 5'd4; mode = 2'd1; start = 1'b1; enable = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset dout", 32'(dout), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset no_done", 32'(done), 32'd0);
    chk("midreset idle", 32'(busy), 32'd0);
    $display("op midreset din=00f0 amt=4 mode=1 dout=%h", dout);

    // Back-to-back: a new start accepted in the done cycle.
    din = 16'h1234; amount = 5'd4; mode = 2'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("b2b first_dout", 32'(dout), 32'h4123);
    din = 16'h8001; amount = 5'd1; mode = 2'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("b2b busy", 32'(busy), 32'd1);
    chk("b2b done_low", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("b2b done", 32'(done), 32'd1);
    chk("b2b dout", 32'(dout), 32'h4000);
    @(posedge clk); #1;
    $display("op b2b din=8001 amt=1 mode=1 dout=%h", dout);

    // Randomized operations with random stalls and ignored start pokes.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] rd;
      logic [4:0]  ra;
      logic [1:0]  rm;
      rd = 16'($urandom); ra = 5'($urandom); rm = 2'($urandom);
      model(rd, ra, rm, r, s, eff);
      do_op($sformatf("rnd%0d", i), rd, ra, rm, -1, 0, 1'b1, 1'($urandom), r, eff, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
